// File: rtl/alu_operand_serdes.sv
// Byte-bus <-> 2-bit-serial ALU operand/result bridge: loads 1|2 bytes, shifts LSB-first, stores 1|2 bytes.
// Latency: load(1|2) + ALU cycles + store(1|2), no extra cycles; IDLE re-entered the cycle after the last store.
// Backpressure: LOAD waits on rd_valid, SHIFT advances only on alu_active, STORE holds wr_data until wr_ready.
// Optional feature macro: SERDES_PARITY_EN (result parity register); undefined ties parity to 0.
module alu_operand_serdes #(
   parameter int REG_BITS = 8,
   parameter int NSHIFT   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                pair,
   input  logic                load_en,
   input  logic                store_en,
   input  logic                rd_valid,
   output logic                rd_ready,
   input  logic [REG_BITS-1:0] rd_data,
   input  logic                alu_active,
   input  logic                op_done,
   output logic [NSHIFT-1:0]   data_in,
   input  logic [NSHIFT-1:0]   data_out,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [REG_BITS-1:0] wr_data,
   output logic                busy,
   output logic                parity
);

   localparam int BW   = 2 * REG_BITS;
   localparam int NCYC = BW / NSHIFT;
   localparam int CW   = $clog2(NCYC);
   localparam logic [CW-1:0] CNT_MAX = CW'(NCYC - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_LO  = 3'd1,
      S_LOAD_HI  = 3'd2,
      S_SHIFT    = 3'd3,
      S_STORE_LO = 3'd4,
      S_STORE_HI = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   data_q, data_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            pair_q, pair_d;
   logic            store_q, store_d;
   logic            enter_shift;

   // Next-state, buffer update and bus/ALU outputs; everything defaults to hold/idle.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      pair_d   = pair_q;
      store_d  = store_q;
      rd_ready = 1'b0;
      wr_valid = 1'b0;
      wr_data  = data_q[REG_BITS-1:0];
      data_in  = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pair_d  = pair;
               store_d = store_en;
               // Without a load the previous result stays in the buffer as the new operand.
               state_d = load_en ? S_LOAD_LO : S_SHIFT;
            end
         end
         S_LOAD_LO: begin
            rd_ready = 1'b1;
            if (rd_valid) begin
               data_d[REG_BITS-1:0] = rd_data;
               if (!pair_q) begin
                  data_d[BW-1:REG_BITS] = '0;
               end
               state_d = pair_q ? S_LOAD_HI : S_SHIFT;
            end
         end
         S_LOAD_HI: begin
            rd_ready = 1'b1;
            if (rd_valid) begin
               data_d[BW-1:REG_BITS] = rd_data;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            data_in = data_q[NSHIFT-1:0];
            if (alu_active) begin
               // Result bits enter at the top of the active width while operand bits leave at the bottom.
               if (pair_q) begin
                  data_d = {data_out, data_q[BW-1:NSHIFT]};
               end else begin
                  data_d[REG_BITS-1:0] = {data_out, data_q[REG_BITS-1:NSHIFT]};
               end
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CW'(1);
               end
               if (op_done) begin
                  state_d = store_q ? S_STORE_LO : S_IDLE;
               end
            end
         end
         S_STORE_LO: begin
            wr_valid = 1'b1;
            wr_data  = data_q[REG_BITS-1:0];
            if (wr_ready) begin
               state_d = pair_q ? S_STORE_HI : S_IDLE;
            end
         end
         S_STORE_HI: begin
            wr_valid = 1'b1;
            wr_data  = data_q[BW-1:REG_BITS];
            if (wr_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      enter_shift = (state_d == S_SHIFT) && (state_q != S_SHIFT);
      if (enter_shift) begin
         cnt_d = '0;
      end
   end

   // State, buffer, counter and latched transaction mode registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         pair_q  <= 1'b0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         pair_q  <= pair_d;
         store_q <= store_d;
      end
   end

   assign busy = (state_q != S_IDLE);

`ifdef SERDES_PARITY_EN
   logic par_q, par_d;
   logic shift_en;

   assign shift_en = (state_q == S_SHIFT) && alu_active;

   // Running XOR of every result bit returned by the ALU during the current shift phase.
   always_comb begin
      par_d = par_q;
      if (enter_shift) begin
         par_d = 1'b0;
      end else if (shift_en) begin
         par_d = par_q ^ (^data_out);
      end
   end

   // Parity register; holds its value until the next shift phase begins.
   always_ff @(posedge clk) begin
      if (reset) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign parity = par_q;
`else
   assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_serdes.sv
module tb_alu_operand_serdes;

   logic       clk = 1'b0;
   logic       reset, start, pair, load_en, store_en;
   logic       rd_valid, rd_ready;
   logic [7:0] rd_data;
   logic       alu_active, op_done;
   logic [1:0] data_in, data_out;
   logic       wr_valid, wr_ready;
   logic [7:0] wr_data;
   logic       busy, parity;

   int total = 0;
   int bad   = 0;
   logic [15:0] mbuf;

   always #5 clk = ~clk;

   alu_operand_serdes #(.REG_BITS(8), .NSHIFT(2)) dut (
      .clk(clk), .reset(reset), .start(start), .pair(pair), .load_en(load_en),
      .store_en(store_en), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .alu_active(alu_active), .op_done(op_done), .data_in(data_in), .data_out(data_out),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .busy(busy), .parity(parity)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; pair = 1'b0; load_en = 1'b0; store_en = 1'b0;
      rd_valid = 1'b0; rd_data = 8'h00; alu_active = 1'b0; op_done = 1'b0;
      data_out = 2'b00; wr_ready = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_rd_ready"}, 32'(rd_ready), 0);
      chk({tag, "_wr_valid"}, 32'(wr_valid), 0);
      chk({tag, "_data_in"}, 32'(data_in), 0);
   endtask

   // One transaction: the model predicts operand stream, stored bytes, new buffer and parity
   // arithmetically; the bench plays bus and ALU with random wait states and ignored pulses.
   task automatic run_txn(input bit p, input bit ld, input bit st, input logic [15:0] opnd,
                          input int mode, input logic [15:0] bv, input int k, input int abort_at);
      int wbits, mask, op, r, upper, lo, exp_par, nrd, nwr;
      int phase, i, j, budget, carry, s;
      logic [15:0] mcur, newbuf;
      wbits = p ? 16 : 8;
      mask  = (1 << wbits) - 1;
      mcur  = ld ? (p ? opnd : {8'h00, opnd[7:0]}) : mbuf;
      op    = p ? int'(mcur) : int'(mcur[7:0]);
      upper = int'(mcur[15:8]);
      r     = (mode == 1) ? ((op + int'(bv)) & mask) : op;
      lo    = ((op >> (2 * k)) | ((r & ((1 << (2 * k)) - 1)) << (wbits - 2 * k))) & mask;
      newbuf = p ? 16'(lo) : {8'(upper), 8'(lo)};
`ifdef SERDES_PARITY_EN
      exp_par = int'(^(r & ((1 << (2 * k)) - 1)));
`else
      exp_par = 0;
`endif
      nrd = ld ? (p ? 2 : 1) : 0;
      nwr = st ? (p ? 2 : 1) : 0;

      @(negedge clk);
      chk("idle_before_start", 32'(busy), 0);
      start = 1'b1; pair = p; load_en = ld; store_en = st;
      phase = ld ? 0 : 1;
      i = 0; j = 0; carry = 0; budget = 0;
      while (phase < 3 && budget < 300) begin
         @(negedge clk);
         budget++;
         start = ($urandom_range(0, 3) == 0);
         pair = 1'($urandom); load_en = 1'($urandom); store_en = 1'($urandom);
         rd_valid = 1'b0; alu_active = 1'b0; op_done = 1'b0; wr_ready = 1'b0; data_out = 2'b00;
         chk("busy", 32'(busy), 1);
         case (phase)
            0: begin
               chk("load_rd_ready", 32'(rd_ready), 1);
               chk("load_wr_valid", 32'(wr_valid), 0);
               chk("load_data_in", 32'(data_in), 0);
               if ($urandom_range(0, 3) != 0) begin
                  rd_valid = 1'b1;
                  rd_data  = (j == 0) ? opnd[7:0] : opnd[15:8];
                  j++;
                  if (j == nrd) begin
                     phase = 1;
                     j = 0;
                  end
               end else begin
                  rd_data = 8'($urandom);
               end
            end
            1: begin
               chk("shift_rd_ready", 32'(rd_ready), 0);
               chk("shift_wr_valid", 32'(wr_valid), 0);
               chk("data_in", 32'(data_in), (op >> (2 * i)) & 3);
               if (abort_at == i) begin
                  reset = 1'b1;
                  phase = 4;
               end else if ($urandom_range(0, 3) != 0) begin
                  alu_active = 1'b1;
                  if (mode == 1) begin
                     s = int'(data_in) + ((int'(bv) >> (2 * i)) & 3) + carry;
                     data_out = 2'(s & 3);
                     carry = s >> 2;
                  end else begin
                     data_out = data_in;
                  end
                  i++;
                  if (i == k) begin
                     op_done = 1'b1;
                     phase = st ? 2 : 3;
                  end
               end else begin
                  op_done  = 1'($urandom);
                  data_out = 2'($urandom);
               end
            end
            2: begin
               chk("store_rd_ready", 32'(rd_ready), 0);
               chk("store_wr_valid", 32'(wr_valid), 1);
               chk("wr_data", 32'(wr_data), (j == 0) ? 32'(newbuf[7:0]) : 32'(newbuf[15:8]));
               if ($urandom_range(0, 2) != 0) begin
                  wr_ready = 1'b1;
                  j++;
                  if (j == nwr) phase = 3;
               end
            end
            default: ;
         endcase
      end
      if (budget >= 300) chk("timeout", 1, 0);
      @(negedge clk);
      idle_inputs();
      check_quiet("after_txn");
      chk("parity", 32'(parity), (phase == 4) ? 0 : exp_par);
      if (phase == 4) begin
         reset = 1'b0;
         mbuf = 16'h0000;
      end else begin
         mbuf = newbuf;
      end
   endtask

   initial begin
      bit p, ld, st;
      int k, n;
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      check_quiet("reset");
      chk("reset_parity", 32'(parity), 0);
      reset = 1'b0;
      mbuf = 16'h0000;

      run_txn(1'b1, 1'b1, 1'b1, 16'h1234, 0, 16'h0000, 8, -1);  // 16-bit MOV echo
      run_txn(1'b0, 1'b1, 1'b1, 16'h00A5, 1, 16'h0001, 4, -1);  // 8-bit ADD 1 -> 0xA6
      run_txn(1'b1, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 8, -1);  // reuse: upper byte must be 0
      run_txn(1'b1, 1'b1, 1'b0, 16'hBEEF, 0, 16'h0000, 8, 2);   // reset during shift
      run_txn(1'b1, 1'b0, 1'b1, 16'h0000, 1, 16'h0003, 8, -1);  // after reset buffer is 0
      run_txn(1'b1, 1'b1, 1'b0, 16'h0007, 0, 16'h0000, 8, -1);  // parity of 0x0007
      run_txn(1'b1, 1'b1, 1'b0, 16'h8001, 0, 16'h0000, 3, -1);  // early op_done rotate

      for (int t = 0; t < 60; t++) begin
         p  = 1'($urandom);
         ld = ($urandom_range(0, 3) != 0);
         n  = p ? 8 : 4;
         if ($urandom_range(0, 4) == 0) begin
            k  = $urandom_range(1, n);
            st = 1'b0;
         end else begin
            k  = n;
            st = 1'($urandom);
         end
         run_txn(p, ld, st, 16'($urandom), $urandom_range(0, 1), 16'($urandom), k,
                 ($urandom_range(0, 19) == 0) ? $urandom_range(0, k - 1) : -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
